// File: rtl/posit_pkg.sv
// Shared types for the posit arithmetic units and their controllers.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package posit_pkg;

   typedef enum logic [1:0] {
      POSIT16,
      POSIT32,
      POSIT8,
      POSIT64
   } posit_format_e;

   function automatic int unsigned posit_width(posit_format_e fmt);
      case (fmt)
         POSIT8:  return 8;
         POSIT32: return 32;
         POSIT64: return 64;
         default: return 16;
      endcase
   endfunction

   typedef enum logic [0:0] {
      DIV,
      SQRT
   } operation_e;

   typedef enum logic [2:0] {
      RNE,
      RTZ,
      RDN,
      RUP,
      RMM
   } roundmode_e;

   // Exception flags in {NV, DZ, OF, UF, NX} order.
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef enum logic [1:0] {
      DSC_IDLE,
      DSC_EXEC,
      DSC_RESP
   } divsqrt_ctrl_state_e;

endpackage

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr (wrapping) wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   IDW      highest-priority index this cycle
//   gnt     out  NUM_REQ  one-hot grant, all zero when nothing requests
//   gnt_id  out  IDW      binary index of the granted requester
module posit_rr_arbiter #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_id
);

   logic           found;
   logic [IDW:0]   sum;
   logic [IDW-1:0] cand;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         // One extra bit so ptr + i cannot overflow before the wrap.
         sum = {1'b0, ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NUM_REQ)) begin
            cand = IDW'(sum - (IDW+1)'(NUM_REQ));
         end else begin
            cand = IDW'(sum);
         end
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_id    = cand;
         end
      end
   end

endmodule

// File: rtl/posit_divsqrt_ctrl.sv
// Shares one posit div/sqrt unit among NUM_REQ requesters; operands are held for a multicycle path.
// Latency: request handshake to resp_valid_o in MCP_CYCLES+1 edges; issue period MCP_CYCLES+2.
// Backpressure: one op in flight; req_ready_o stays low until the response is taken or flushed.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   flush_i                           drop the operation in flight (also forwarded on du_flush_o)
//   req_valid_i/req_ready_o           per-requester request handshake, ready is one-hot or zero
//   req_operands_i/op/rnd_mode/tag    per-requester payload ([r][0]=a, [r][1]=b)
//   resp_valid_o/resp_ready_i         one-hot response handshake back to the issuing requester
//   resp_result_o/status_o/tag_o      shared response payload
//   du_*                              registered operands to the unit and its result inputs
//   busy_o                            an operation is in EXEC or RESP
module posit_divsqrt_ctrl import posit_pkg::*; #(
   parameter  posit_format_e pFormat    = posit_format_e'(0),
   parameter  int unsigned   NUM_REQ    = 2,
   parameter  int unsigned   MCP_CYCLES = 4,
   localparam int unsigned   WIDTH      = posit_width(pFormat)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,

   input  logic       [NUM_REQ-1:0]          req_valid_i,
   output logic       [NUM_REQ-1:0]          req_ready_o,
   input  logic       [NUM_REQ-1:0][1:0][WIDTH-1:0] req_operands_i,
   input  operation_e [NUM_REQ-1:0]          req_op_i,
   input  roundmode_e [NUM_REQ-1:0]          req_rnd_mode_i,
   input  logic       [NUM_REQ-1:0]          req_tag_i,

   output logic       [NUM_REQ-1:0]          resp_valid_o,
   input  logic       [NUM_REQ-1:0]          resp_ready_i,
   output logic       [WIDTH-1:0]            resp_result_o,
   output status_t                           resp_status_o,
   output logic                              resp_tag_o,

   output logic       [1:0][WIDTH-1:0]       du_operands_o,
   output operation_e                        du_op_o,
   output roundmode_e                        du_rnd_mode_o,
   output logic                              du_tag_o,
   output logic                              du_in_valid_o,
   input  logic                              du_in_ready_i,
   input  logic       [WIDTH-1:0]            du_result_i,
   input  status_t                           du_status_i,
   input  logic                              du_tag_i,
   input  logic                              du_out_valid_i,
   output logic                              du_out_ready_o,
   output logic                              du_flush_o,

   output logic                              busy_o
);

   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW  = $clog2(MCP_CYCLES + 1);

   divsqrt_ctrl_state_e state_q, state_d;

   logic [IDW-1:0]        rr_ptr_q;
   logic [IDW-1:0]        id_q;
   logic [CW-1:0]         cnt_q;
   logic [NUM_REQ-1:0]    gnt;
   logic [IDW-1:0]        gnt_id;

   logic [1:0][WIDTH-1:0] operands_q;
   operation_e            op_q;
   roundmode_e            rnd_q;
   logic                  tag_q;

   logic [WIDTH-1:0]      res_q;
   status_t               status_q;
   logic                  res_tag_q;

   logic                  accept;
   logic                  capture;
   logic                  cnt_last;

   posit_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req    (req_valid_i),
      .ptr    (rr_ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // The unit's result is only trusted once the operands have been stable
   // for the full multicycle window.
   assign cnt_last = (cnt_q == CW'(MCP_CYCLES - 1));

   always_comb begin
      state_d        = state_q;
      req_ready_o    = '0;
      resp_valid_o   = '0;
      du_in_valid_o  = 1'b0;
      du_out_ready_o = 1'b0;
      accept         = 1'b0;
      capture        = 1'b0;
      case (state_q)
         DSC_IDLE: begin
            // Reset and flush both outrank a handshake, so ready is masked.
            if (!rst_i && !flush_i) begin
               req_ready_o = gnt;
               if (|gnt) begin
                  accept  = 1'b1;
                  state_d = DSC_EXEC;
               end
            end
         end
         DSC_EXEC: begin
            du_in_valid_o  = 1'b1;
            du_out_ready_o = 1'b1;
            if (flush_i) begin
               state_d = DSC_IDLE;
            end else if (cnt_last && du_in_ready_i && du_out_valid_i) begin
               capture = 1'b1;
               state_d = DSC_RESP;
            end
         end
         DSC_RESP: begin
            // A flushed result must not complete a handshake, so valid drops with flush.
            if (flush_i) begin
               state_d = DSC_IDLE;
            end else begin
               resp_valid_o[id_q] = 1'b1;
               if (resp_ready_i[id_q]) begin
                  state_d = DSC_IDLE;
               end
            end
         end
         default: begin
            state_d = DSC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= DSC_IDLE;
         rr_ptr_q   <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         operands_q <= '0;
         op_q       <= operation_e'(0);
         rnd_q      <= roundmode_e'(0);
         tag_q      <= 1'b0;
         res_q      <= '0;
         status_q   <= '0;
         res_tag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            operands_q <= req_operands_i[gnt_id];
            op_q       <= req_op_i[gnt_id];
            rnd_q      <= req_rnd_mode_i[gnt_id];
            tag_q      <= req_tag_i[gnt_id];
            id_q       <= gnt_id;
            rr_ptr_q   <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
            cnt_q      <= '0;
         end else if (state_q == DSC_EXEC && !cnt_last) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (capture) begin
            res_q     <= du_result_i;
            status_q  <= du_status_i;
            res_tag_q <= du_tag_i;
         end
      end
   end

   assign du_operands_o = operands_q;
   assign du_op_o       = op_q;
   assign du_rnd_mode_o = rnd_q;
   assign du_tag_o      = tag_q;
   assign du_flush_o    = flush_i;
   assign resp_result_o = res_q;
   assign resp_status_o = status_q;
   assign resp_tag_o    = res_tag_q;
   assign busy_o        = (state_q != DSC_IDLE);

endmodule

// File: tb/tb_posit_divsqrt_ctrl.sv
// Bench for posit_divsqrt_ctrl with a toy div/sqrt unit model and a response scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low.
module tb_posit_divsqrt_ctrl;
   import posit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (MCP_CYCLES = 4) ----------------
   logic                    rst, flush;
   logic       [1:0]        req_valid, req_ready, req_tag;
   logic       [1:0][1:0][15:0] req_operands;
   operation_e [1:0]        req_op;
   roundmode_e [1:0]        req_rnd;
   logic       [1:0]        resp_valid, resp_ready;
   logic       [15:0]       resp_result;
   status_t                 resp_status;
   logic                    resp_tag;
   logic       [1:0][15:0]  du_ops;
   operation_e              du_op;
   roundmode_e              du_rnd;
   logic                    du_tag, du_in_valid, du_in_ready, du_out_ready, du_flush, busy;
   logic       [20:0]       du_model;

   // ---------------- second DUT (MCP_CYCLES = 1) ----------------
   logic       [1:0]        m1_req_valid, m1_req_ready, m1_resp_valid;
   logic       [15:0]       m1_result;
   status_t                 m1_status;
   logic                    m1_rtag, m1_du_tag, m1_du_in_valid, m1_du_out_ready, m1_du_flush, m1_busy;
   logic       [1:0][15:0]  m1_du_ops;
   operation_e              m1_du_op;
   roundmode_e              m1_du_rnd;
   logic       [20:0]       m1_model;

   int n_checks = 0;
   int n_errors = 0;

   // Toy stand-in for posit_divsqrt: {status[4:0], result[15:0]}.
   function automatic logic [20:0] unit_model(input logic [15:0] a, input logic [15:0] b,
                                              input operation_e op);
      if (op == DIV) begin
         if (b == 16'h0000) return {5'b11000, 16'h8000};
         if (a == b)        return {5'b00000, 16'h4000};
         return {5'b00001, a - b};
      end
      if (a == 16'h4000) return {5'b00000, 16'h4000};
      return {5'b00001, 1'b0, a[15:1]};
   endfunction

   assign du_model = unit_model(du_ops[0], du_ops[1], du_op);
   assign m1_model = unit_model(m1_du_ops[0], m1_du_ops[1], m1_du_op);

   posit_divsqrt_ctrl #(.NUM_REQ(2), .MCP_CYCLES(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
      .req_op_i(req_op), .req_rnd_mode_i(req_rnd), .req_tag_i(req_tag),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
      .resp_status_o(resp_status), .resp_tag_o(resp_tag),
      .du_operands_o(du_ops), .du_op_o(du_op), .du_rnd_mode_o(du_rnd), .du_tag_o(du_tag),
      .du_in_valid_o(du_in_valid), .du_in_ready_i(du_in_ready),
      .du_result_i(du_model[15:0]), .du_status_i(status_t'(du_model[20:16])),
      .du_tag_i(du_tag), .du_out_valid_i(du_in_valid), .du_out_ready_o(du_out_ready),
      .du_flush_o(du_flush), .busy_o(busy)
   );

   posit_divsqrt_ctrl #(.NUM_REQ(2), .MCP_CYCLES(1)) u_dut_m1 (
      .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
      .req_valid_i(m1_req_valid), .req_ready_o(m1_req_ready), .req_operands_i(req_operands),
      .req_op_i(req_op), .req_rnd_mode_i(req_rnd), .req_tag_i(req_tag),
      .resp_valid_o(m1_resp_valid), .resp_ready_i(2'b11), .resp_result_o(m1_result),
      .resp_status_o(m1_status), .resp_tag_o(m1_rtag),
      .du_operands_o(m1_du_ops), .du_op_o(m1_du_op), .du_rnd_mode_o(m1_du_rnd), .du_tag_o(m1_du_tag),
      .du_in_valid_o(m1_du_in_valid), .du_in_ready_i(1'b1),
      .du_result_i(m1_model[15:0]), .du_status_i(status_t'(m1_model[20:16])),
      .du_tag_i(m1_du_tag), .du_out_valid_i(m1_du_in_valid), .du_out_ready_o(m1_du_out_ready),
      .du_flush_o(m1_du_flush), .busy_o(m1_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic [15:0] res;
      logic [4:0]  st;
      logic        tag;
   } exp_t;

   exp_t        sb[$];
   int          gnt_log[$];
   exp_t        mon_e;
   logic [20:0] mon_m;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               mon_m     = unit_model(req_operands[r][0], req_operands[r][1], req_op[r]);
               mon_e.id  = r;
               mon_e.res = mon_m[15:0];
               mon_e.st  = mon_m[20:16];
               mon_e.tag = req_tag[r];
               sb.push_back(mon_e);
               gnt_log.push_back(r);
            end
         end
         if (flush && busy) begin
            if (sb.size() > 0) void'(sb.pop_front());
         end else if ((resp_valid & resp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", {30'b0, resp_valid}, 32'h0);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_id", {30'b0, resp_valid}, 32'(1 << mon_e.id));
               chk("resp_result", {16'b0, resp_result}, {16'b0, mon_e.res});
               chk("resp_status", {27'b0, resp_status}, {27'b0, mon_e.st});
               chk("resp_tag", {31'b0, resp_tag}, {31'b0, mon_e.tag});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b, input operation_e op);
      req_operands[r][0] = a;
      req_operands[r][1] = b;
      req_op[r]          = op;
      req_valid[r]       = 1'b1;
   endtask

   task automatic wait_hs(input int r);
      bit ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (req_valid[r] && req_ready[r]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("hs_seen", {31'b0, ok}, 32'h1);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_resp();
      bit ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      chk("resp_seen", {31'b0, ok}, 32'h1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain", {31'b0, ok}, 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hs;
      int got;

      rst          = 1'b1;
      flush        = 1'b0;
      req_valid    = 2'b00;
      m1_req_valid = 2'b00;
      req_operands = '0;
      req_op[0]    = DIV;
      req_op[1]    = DIV;
      req_rnd[0]   = RNE;
      req_rnd[1]   = RTZ;
      req_tag      = 2'b10;
      resp_ready   = 2'b11;
      du_in_ready  = 1'b1;

      // Reset state.
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_resp_valid", {30'b0, resp_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_du_in_valid", {31'b0, du_in_valid}, 32'h0);
      chk("rst_du_out_ready", {31'b0, du_out_ready}, 32'h0);
      chk("rst_du_ops", {du_ops[1], du_ops[0]}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: single DIV 1.0/1.0, latency MCP+1 edges.
      set_req(0, 16'h4000, 16'h4000, DIV);
      @(negedge clk);
      chk("t1_req_ready", {30'b0, req_ready}, 32'h1);
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (n == 1) req_valid[0] = 1'b0;
         @(negedge clk);
         if (n == 2) begin
            chk("t1_du_in_valid", {31'b0, du_in_valid}, 32'h1);
            chk("t1_du_out_ready", {31'b0, du_out_ready}, 32'h1);
            chk("t1_busy", {31'b0, busy}, 32'h1);
            chk("t1_du_ops", {du_ops[1], du_ops[0]}, 32'h4000_4000);
         end
         if (resp_valid != 2'b00) begin
            lat = n;
            break;
         end
      end
      chk("t1_latency", lat, 5);
      chk("t1_resp_valid", {30'b0, resp_valid}, 32'h1);
      chk("t1_result", {16'b0, resp_result}, 32'h4000);
      chk("t1_status", {27'b0, resp_status}, 32'h0);
      @(posedge clk); #1;

      // 3: divide by zero from requester 1, with the unit stalling via du_in_ready.
      du_in_ready = 1'b0;
      set_req(1, 16'h3000, 16'h0000, DIV);
      wait_hs(1);
      repeat (6) begin
         @(negedge clk);
         chk("t3_stall", {30'b0, resp_valid}, 32'h0);
         @(posedge clk); #1;
      end
      du_in_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t3_resp_valid", {30'b0, resp_valid}, 32'h2);
      chk("t3_result", {16'b0, resp_result}, 32'h8000);
      chk("t3_status", {27'b0, resp_status}, 32'h18);
      drain();

      // 2: both requesters valid every cycle, six operations, strict alternation.
      gnt_log.delete();
      set_req(0, 16'h5000, 16'h4000, DIV);
      set_req(1, 16'h4800, 16'h0000, SQRT);
      hs = 0;
      for (int n = 0; n < 200 && hs < 6; n++) begin
         @(negedge clk);
         got = -1;
         for (int r = 0; r < 2; r++) if (req_valid[r] && req_ready[r]) got = r;
         @(posedge clk); #1;
         if (got >= 0) begin
            hs++;
            req_operands[got][0] = req_operands[got][0] + 16'h0100;
         end
      end
      req_valid = 2'b00;
      drain();
      chk("t2_count", gnt_log.size(), 6);
      for (int i = 0; i < gnt_log.size() && i < 6; i++) chk("t2_order", gnt_log[i], i % 2);

      // 4: response backpressure for 10 cycles while requester 1 waits.
      resp_ready = 2'b00;
      set_req(0, 16'h6100, 16'h2000, DIV);
      wait_hs(0);
      set_req(1, 16'h4000, 16'h4000, SQRT);
      wait_resp();
      for (int i = 0; i < 10; i++) begin
         chk("t4_resp_valid", {30'b0, resp_valid}, 32'h1);
         chk("t4_result", {16'b0, resp_result}, 32'h4100);
         chk("t4_req_ready", {30'b0, req_ready}, 32'h0);
         chk("t4_busy", {31'b0, busy}, 32'h1);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 2'b11;
      wait_hs(1);
      drain();

      // 5: flush in IDLE blocks acceptance; flush in EXEC cycle 2 drops the op.
      flush = 1'b1;
      set_req(0, 16'h5000, 16'h5000, DIV);
      @(negedge clk);
      chk("t5_idle_flush_ready", {30'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
      flush = 1'b0;
      wait_hs(0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("t5_du_flush", {31'b0, du_flush}, 32'h1);
      @(posedge clk); #1;
      flush = 1'b0;
      set_req(1, 16'h4000, 16'h4000, DIV);
      @(negedge clk);
      chk("t5_idle_after_flush", {31'b0, busy}, 32'h0);
      chk("t5_accept", {30'b0, req_ready}, 32'h2);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t5_no_resp_for_flushed", {30'b0, resp_valid & 2'b01}, 32'h0);
      end
      drain();

      // 6: reset while in RESP clears everything and rr_ptr.
      resp_ready = 2'b00;
      set_req(0, 16'h4000, 16'h3000, DIV);
      wait_hs(0);
      wait_resp();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_resp_valid", {30'b0, resp_valid}, 32'h0);
      chk("t6_busy", {31'b0, busy}, 32'h0);
      chk("t6_du_in_valid", {31'b0, du_in_valid}, 32'h0);
      chk("t6_du_out_ready", {31'b0, du_out_ready}, 32'h0);
      chk("t6_du_ops", {du_ops[1], du_ops[0]}, 32'h0);
      @(posedge clk); #1;
      resp_ready = 2'b11;
      set_req(0, 16'h4400, 16'h4000, DIV);
      set_req(1, 16'h4000, 16'h4000, SQRT);
      @(negedge clk);
      chk("t6_rr_ptr_reset", {30'b0, req_ready}, 32'h1);
      wait_hs(0);
      wait_hs(1);
      drain();

      // MCP_CYCLES = 1 instance: latency 2.
      req_operands[0][0] = 16'h4000;
      req_operands[0][1] = 16'h4000;
      req_op[0]          = DIV;
      m1_req_valid       = 2'b01;
      @(negedge clk);
      chk("m1_req_ready", {30'b0, m1_req_ready}, 32'h1);
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (n == 1) m1_req_valid = 2'b00;
         @(negedge clk);
         if (m1_resp_valid != 2'b00) begin
            lat = n;
            break;
         end
      end
      chk("m1_latency", lat, 2);
      chk("m1_result", {16'b0, m1_result}, 32'h4000);
      @(posedge clk); #1;

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
